// File: rtl/psum_acc_quant.sv
// Adder-tree back end: tracks valid through the 3-stage tree, accumulates psums per group,
// adds bias, shifts, saturates, and drives pipe_en from output backpressure. Optional ReLU: PSUM_ACC_RELU_EN.
module psum_acc_quant #(
    parameter int PSUM_WIDTH = 32,
    parameter int ACC_WIDTH  = 40,
    parameter int BIAS_WIDTH = 32,
    parameter int OUT_WIDTH  = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_vld,
    input  logic signed [PSUM_WIDTH-1:0] psum,
    output logic                         pipe_en,
    input  logic        [CNT_WIDTH-1:0]  cfg_tiles,
    input  logic        [5:0]            cfg_shift,
    input  logic signed [BIAS_WIDTH-1:0] bias,
    output logic                         out_vld,
    input  logic                         out_rdy,
    output logic signed [OUT_WIDTH-1:0]  out_data,
    output logic                         busy
);

    localparam logic signed [ACC_WIDTH-1:0] SAT_HI = ACC_WIDTH'(2**(OUT_WIDTH-1) - 1);
`ifdef PSUM_ACC_RELU_EN
    localparam logic signed [ACC_WIDTH-1:0] SAT_LO = '0;
`else
    localparam logic signed [ACC_WIDTH-1:0] SAT_LO = ACC_WIDTH'(-(2**(OUT_WIDTH-1)));
`endif

    logic [2:0]                   vld_pipe_q, vld_pipe_d;
    logic [CNT_WIDTH-1:0]         tile_cnt_q, tile_cnt_d;
    logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic                         out_vld_q, out_vld_d;
    logic signed [OUT_WIDTH-1:0]  out_data_q, out_data_d;

    logic                         consume;
    logic                         first;
    logic                         last;
    logic [CNT_WIDTH-1:0]         tiles_eff;
    logic signed [ACC_WIDTH-1:0]  psum_ext;
    logic signed [ACC_WIDTH-1:0]  bias_ext;
    logic signed [ACC_WIDTH-1:0]  acc_n;
    logic signed [ACC_WIDTH-1:0]  shifted;

    // A stalled output beat freezes the whole tree, so nothing upstream can overrun it.
    assign pipe_en   = !(out_vld_q && !out_rdy);
    assign consume   = vld_pipe_q[2] && pipe_en;
    assign tiles_eff = (cfg_tiles == '0) ? CNT_WIDTH'(1) : cfg_tiles;
    assign first     = (tile_cnt_q == '0);
    assign last      = (tile_cnt_q == tiles_eff - CNT_WIDTH'(1));
    assign psum_ext  = ACC_WIDTH'(psum);
    assign bias_ext  = ACC_WIDTH'(bias);
    assign acc_n     = first ? (psum_ext + bias_ext) : (acc_q + psum_ext);
    assign shifted   = acc_n >>> cfg_shift;

    always_comb begin
        vld_pipe_d = vld_pipe_q;
        tile_cnt_d = tile_cnt_q;
        acc_d      = acc_q;
        out_vld_d  = out_vld_q;
        out_data_d = out_data_q;

        if (pipe_en) begin
            vld_pipe_d = {vld_pipe_q[1:0], in_vld};
        end

        if (consume) begin
            if (last) begin
                tile_cnt_d = '0;
                acc_d      = '0;
            end else begin
                tile_cnt_d = tile_cnt_q + CNT_WIDTH'(1);
                acc_d      = acc_n;
            end
        end

        // A final consume may land in the same cycle the previous beat drains.
        if (consume && last) begin
            out_vld_d = 1'b1;
            if (shifted > SAT_HI) begin
                out_data_d = SAT_HI[OUT_WIDTH-1:0];
            end else if (shifted < SAT_LO) begin
                out_data_d = SAT_LO[OUT_WIDTH-1:0];
            end else begin
                out_data_d = shifted[OUT_WIDTH-1:0];
            end
        end else if (out_rdy) begin
            out_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_pipe_q <= '0;
            tile_cnt_q <= '0;
            acc_q      <= '0;
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
            tile_cnt_q <= tile_cnt_d;
            acc_q      <= acc_d;
            out_vld_q  <= out_vld_d;
            out_data_q <= out_data_d;
        end
    end

    assign out_vld  = out_vld_q;
    assign out_data = out_data_q;
    assign busy     = (|vld_pipe_q) || (tile_cnt_q != '0) || out_vld_q;

endmodule

// File: tb/tb_psum_acc_quant.sv
// Bench for psum_acc_quant: a 3-stage delay stands in for the adder tree, a group-level
// model predicts each output, and one compare process checks the output port every cycle.
module tb_psum_acc_quant;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_vld;
    logic signed [31:0] psum;
    logic              pipe_en;
    logic [7:0]        cfg_tiles;
    logic [5:0]        cfg_shift;
    logic signed [31:0] bias;
    logic              out_vld;
    logic              out_rdy;
    logic signed [7:0] out_data;
    logic              busy;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic signed [31:0] in_psum;
    logic signed [31:0] t0, t1, t2;

    int     exp_q[$];
    int     got[$];
    int     hs_cyc[$];
    int     m_cnt;
    longint m_acc;

    psum_acc_quant dut (
        .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .psum(psum), .pipe_en(pipe_en),
        .cfg_tiles(cfg_tiles), .cfg_shift(cfg_shift), .bias(bias),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in for the 3-register adder tree, frozen by pipe_en like the real one.
    always @(posedge clk) begin
        if (!rst_n) begin
            t0 <= '0; t1 <= '0; t2 <= '0;
        end else if (pipe_en) begin
            t0 <= in_psum; t1 <= t0; t2 <= t1;
        end
    end
    assign psum = t2;

    task automatic chk(string name, longint act, longint expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    function automatic longint wrap40(longint x);
        return (x <<< 24) >>> 24;
    endfunction

    function automatic int quant_ref(longint a, int sh);
        longint s;
        s = a >>> sh;
`ifdef PSUM_ACC_RELU_EN
        if (s < 0) s = 0;
`endif
        if (s > 127) return 127;
        if (s < -128) return -128;
        return int'(s);
    endfunction

    // Group-level model: called once per accepted beat.
    task automatic model_beat(int v);
        int te;
        te = (cfg_tiles == 0) ? 1 : int'(cfg_tiles);
        if (m_cnt == 0) m_acc = wrap40(longint'(v) + longint'(bias));
        else            m_acc = wrap40(m_acc + longint'(v));
        m_cnt++;
        if (m_cnt == te) begin
            exp_q.push_back(quant_ref(m_acc, int'(cfg_shift)));
            m_cnt = 0;
        end
    endtask

    // Compare process: every cycle out of reset.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("pipe_en", pipe_en, !(out_vld && !out_rdy));
            if (out_vld) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out_vld", out_vld, 0);
                end else begin
                    chk("out_data", int'(out_data), exp_q[0]);
                    if (out_rdy) begin
                        got.push_back(int'(out_data));
                        hs_cyc.push_back(cyc);
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic send(int v);
        bit ok = 0;
        int n  = 0;
        in_vld  = 1'b1;
        in_psum = v;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = pipe_en;
            @(posedge clk); #1;
            n++;
        end
        in_vld = 1'b0;
        if (!ok) chk("send_timeout", 0, 1);
        else     model_beat(v);
    endtask

    task automatic drain();
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_done", (busy || exp_q.size() != 0), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_cnt = 0;
        m_acc = 0;
        exp_q.delete();
    endtask

    initial begin
        rst_n = 1'b0; in_vld = 1'b0; in_psum = '0; out_rdy = 1'b1;
        cfg_tiles = 8'd4; cfg_shift = 6'd2; bias = 32'sd5;
        m_cnt = 0; m_acc = 0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        chk("rst_out_vld", out_vld, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_pipe_en", pipe_en, 1);
        chk("rst_busy", busy, 0);

        // Group: 10+20+30+40+5 = 105, >>>2 = 26, four cycles after the last in_vld.
        got.delete();
        send(10); send(20); send(30); send(40);
        repeat (3) @(negedge clk);
        chk("lat_not_yet", out_vld, 0);
        @(negedge clk);
        chk("lat_out_vld", out_vld, 1);
        chk("lat_out_data", int'(out_data), 26);
        drain();
        chk("grp_count", got.size(), 1);
        if (got.size() >= 1) chk("grp_val", got[0], 26);

        // Saturation.
        got.delete();
        cfg_tiles = 8'd1; bias = 0; cfg_shift = 6'd0;
        send(1000); send(-1000);
        drain();
        cfg_shift = 6'd1;
        send(-3);
        drain();
        chk("sat_count", got.size(), 3);
        if (got.size() == 3) begin
            chk("sat_hi", got[0], 127);
`ifdef PSUM_ACC_RELU_EN
            chk("sat_lo", got[1], 0);
            chk("shift_neg", got[2], 0);
`else
            chk("sat_lo", got[1], -128);
            chk("shift_neg", got[2], -2);
`endif
        end

        // Backpressure: hold out_rdy low for 5 cycles once the first result appears.
        got.delete();
        cfg_shift = 6'd0;
        out_rdy = 1'b0;
        fork
            begin
                for (int i = 1; i <= 6; i++) send(i);
            end
            begin
                int n = 0;
                while (!out_vld && n < 50) begin @(negedge clk); n++; end
                chk("bp_first_vld", out_vld, 1);
                for (int k = 0; k < 5; k++) begin
                    chk("bp_stall_pipe_en", pipe_en, 0);
                    chk("bp_hold_data", int'(out_data), 1);
                    @(negedge clk);
                end
                @(posedge clk); #1;
                out_rdy = 1'b1;
            end
        join
        drain();
        chk("bp_count", got.size(), 6);
        for (int i = 0; i < got.size() && i < 6; i++) chk("bp_order", got[i], i + 1);

        // cfg_tiles = 0 acts as 1.
        got.delete();
        cfg_tiles = 8'd0; bias = 7;
        send(1); send(2); send(3);
        drain();
        chk("t0_count", got.size(), 3);
        if (got.size() == 3) begin
            chk("t0_a", got[0], 8); chk("t0_b", got[1], 9); chk("t0_c", got[2], 10);
        end

        // Reset in the middle of a group.
        got.delete();
        cfg_tiles = 8'd4; bias = 0;
        send(50); send(50);
        repeat (5) @(posedge clk);
        #1;
        do_reset();
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_out_vld", out_vld, 0);
        send(1); send(1); send(1); send(1);
        drain();
        chk("mid_rst_count", got.size(), 1);
        if (got.size() == 1) chk("mid_rst_val", got[0], 4);

        // Back-to-back groups of two.
        got.delete();
        hs_cyc.delete();
        cfg_tiles = 8'd2;
        for (int i = 1; i <= 8; i++) send(i);
        drain();
        chk("b2b_count", got.size(), 4);
        if (got.size() == 4) begin
            chk("b2b_0", got[0], 3);  chk("b2b_1", got[1], 7);
            chk("b2b_2", got[2], 11); chk("b2b_3", got[3], 15);
            for (int i = 1; i < 4; i++) chk("b2b_spacing", hs_cyc[i] - hs_cyc[i-1], 2);
        end

        // tiles=1 streaming: one result every cycle, no gap.
        got.delete();
        hs_cyc.delete();
        cfg_tiles = 8'd1;
        for (int i = 0; i < 4; i++) send(i * 3);
        drain();
        chk("stream_count", got.size(), 4);
        if (got.size() == 4)
            for (int i = 1; i < 4; i++) chk("stream_spacing", hs_cyc[i] - hs_cyc[i-1], 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
